// File: rtl/axi_lite_mem_responder_if.sv
// rtl/axi_lite_mem_responder_if.sv - AXI4-Lite bus bundle between a master and the memory responder
interface axi_lite_mem_responder_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
);
  // read address channel
  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  // read data channel
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  // write address channel
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  // write data channel
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  // write response channel
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;

  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
endinterface

// File: rtl/axi_lite_mem_responder.sv
// rtl/axi_lite_mem_responder.sv - AXI4-Lite slave backed by a word array with fixed response latency
module axi_lite_mem_responder #(
  parameter int                ADDR_W = 17,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = 17'h10000,
  parameter int                RD_LAT = 2,
  parameter int                WR_LAT = 2
) (
  input logic                     clk,
  input logic                     rst,
  axi_lite_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Inclusive byte-address window, one bit wider than the bus so BASE+size cannot wrap.
  localparam logic [ADDR_W:0] ADDR_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0] ADDR_HI = ADDR_LO + (ADDR_W + 1)'(DEPTH * 8 - 1);

  // Counter preloads: the response rises LAT edges after the handshake edge.
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                r_valid_q, r_valid_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic                b_valid_q, b_valid_d;
  logic [1:0]          b_resp_q, b_resp_d;
  logic                w_ready_q, w_ready_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  logic                ar_hit;
  logic [IDX_W-1:0]    ar_idx;
  logic                wr_hit;
  logic [IDX_W-1:0]    wr_idx;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] ext;
    ext = {1'b0, a};
    return (ext >= ADDR_LO) && (ext <= ADDR_HI) && (a[2:0] == 3'b000);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - ADDR_LO;
    return IDX_W'(off >> 3);
  endfunction

  // Reads decode the live AR address; writes decode the address latched at AW.
  assign ar_hit = addr_hit(bus.AR_ADDR);
  assign ar_idx = addr_index(bus.AR_ADDR);
  assign wr_hit = addr_hit(addr_q);
  assign wr_idx = addr_index(addr_q);

  assign bus.AR_READY = (state_q == IDLE);
  assign bus.AW_READY = (state_q == IDLE) && !bus.AR_VALID;
  assign bus.R_VALID  = r_valid_q;
  assign bus.R_DATA   = r_data_q;
  assign bus.R_RESP   = r_resp_q;
  assign bus.B_VALID  = b_valid_q;
  assign bus.B_RESP   = b_resp_q;
  assign bus.W_READY  = w_ready_q;

  // Next-state and registered-output logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    w_ready_d = w_ready_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.AR_VALID) begin
          // Read data is captured now so it reflects memory at the AR handshake.
          addr_d  = bus.AR_ADDR;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
          if (ar_hit) begin
            r_data_d = mem_q[ar_idx];
            r_resp_d = RESP_OKAY;
          end else begin
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
          end
        end else if (bus.AW_VALID) begin
          addr_d    = bus.AW_ADDR;
          state_d   = WR_DATA;
          w_ready_d = 1'b1;
        end
      end

      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RD_RESP;
          r_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RD_RESP: begin
        if (bus.R_READY) begin
          state_d   = IDLE;
          r_valid_d = 1'b0;
        end
      end

      WR_DATA: begin
        if (bus.W_VALID) begin
          mem_we    = wr_hit;
          w_ready_d = 1'b0;
          cnt_d     = WR_LOAD;
          state_d   = WR_WAIT;
          b_resp_d  = wr_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end

      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = WR_RESP;
          b_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WR_RESP: begin
        if (bus.B_READY) begin
          state_d   = IDLE;
          b_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
      w_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      w_ready_q <= w_ready_d;
    end
  end

  // Storage array; deliberately not reset so committed writes survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_idx] <= bus.W_DATA;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// tb/tb_axi_lite_mem_responder.sv - randomized self-checking bench for axi_lite_mem_responder
module tb_axi_lite_mem_responder;

  localparam int BASE_I = 'h10000;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [63:0] model_mem [DEPTH];

  axi_lite_mem_responder_if #(.ADDR_W(17), .DATA_W(64)) bus ();

  axi_lite_mem_responder #(
    .ADDR_W(17), .DATA_W(64), .DEPTH(DEPTH), .BASE(17'h10000),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic bit m_hit(input logic [16:0] a);
    int v;
    v = int'(a);
    return (v >= BASE_I) && (v < BASE_I + DEPTH * 8) && (v % 8 == 0);
  endfunction

  function automatic int m_idx(input logic [16:0] a);
    return (int'(a) - BASE_I) / 8;
  endfunction

  function automatic logic [16:0] pick_addr();
    int c;
    int v;
    c = int'($urandom_range(0, 9));
    if (c < 6)       v = BASE_I + 8 * int'($urandom_range(0, DEPTH - 1));
    else if (c == 6) v = BASE_I + 8 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(1, 7));
    else if (c == 7) v = int'($urandom_range(0, BASE_I - 1));
    else if (c == 8) v = BASE_I + DEPTH * 8 + int'($urandom_range(0, 'h1FFFF - BASE_I - DEPTH * 8));
    else             v = ($urandom_range(0, 1) == 0) ? BASE_I - 8 : BASE_I + DEPTH * 8;
    return 17'(v);
  endfunction

  task automatic do_read(input logic [16:0] addr, output logic [63:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    lat  = -1;
    data = '0;
    resp = 2'b11;
    @(posedge clk); #1;
    bus.AR_VALID = 1'b1;
    bus.AR_ADDR  = addr;
    n = 0;
    @(negedge clk);
    while (!bus.AR_READY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.R_VALID) begin lat = k; break; end
    end
    if (lat >= 0) begin
      data = bus.R_DATA;
      resp = bus.R_RESP;
      bus.R_READY = 1'b1;
      @(posedge clk); #1;
      bus.R_READY = 1'b0;
    end
  endtask

  task automatic do_write(input logic [16:0] addr, input logic [63:0] data, input int w_early,
                          output logic [1:0] resp, output int lat, output int early_ready);
    int n;
    lat = -1;
    resp = 2'b11;
    early_ready = 0;
    @(posedge clk); #1;
    if (w_early > 0) begin
      bus.W_VALID = 1'b1;
      bus.W_DATA  = data;
      for (int k = 0; k < w_early; k++) begin
        @(negedge clk);
        if (bus.W_READY) early_ready++;
        @(posedge clk); #1;
      end
    end
    bus.AW_VALID = 1'b1;
    bus.AW_ADDR  = addr;
    n = 0;
    @(negedge clk);
    if (bus.W_READY) early_ready++;
    while (!bus.AW_READY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b1;
    bus.W_DATA   = data;
    n = 0;
    @(negedge clk);
    while (!bus.W_READY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.W_VALID = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.B_VALID) begin lat = k; break; end
    end
    if (lat >= 0) begin
      resp = bus.B_RESP;
      bus.B_READY = 1'b1;
      @(posedge clk); #1;
      bus.B_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.R_READY = 1'b0;
    bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.W_VALID = 1'b0;
    bus.W_DATA = '0; bus.B_READY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.R_VALID, bus.B_VALID, bus.W_READY} !== 3'b000) $display("FAIL reset_valids: got %b expected 000", {bus.R_VALID, bus.B_VALID, bus.W_READY});
    else n_pass++;
    n_total++;
    if ({bus.R_DATA, bus.R_RESP, bus.B_RESP} !== 68'h0) $display("FAIL reset_data_resp: got %h expected 0", {bus.R_DATA, bus.R_RESP, bus.B_RESP});
    else n_pass++;
    n_total++;
    if ({bus.AR_READY, bus.AW_READY} !== 2'b11) $display("FAIL reset_ready_idle: got %b expected 11", {bus.AR_READY, bus.AW_READY});
    else n_pass++;
    bus.AR_VALID = 1'b1;
    #1;
    n_total++;
    if ({bus.AR_READY, bus.AW_READY} !== 2'b10) $display("FAIL reset_ready_arvalid: got %b expected 10", {bus.AR_READY, bus.AW_READY});
    else n_pass++;
    bus.AR_VALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [63:0] d;
    logic [1:0]  resp;
    int lat, er, bad_resp, bad_lat;
    bad_resp = 0;
    bad_lat  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = {$urandom, $urandom};
      do_write(17'(BASE_I + i * 8), d, 0, resp, lat, er);
      model_mem[i] = d;
      if (resp !== 2'b00) bad_resp++;
      if (lat != WR_LAT) bad_lat++;
    end
    n_total++;
    if (bad_resp != 0) $display("FAIL fill_resp: got %0d bad responses expected 0", bad_resp);
    else n_pass++;
    n_total++;
    if (bad_lat != 0) $display("FAIL fill_latency: got %0d wrong latencies expected 0", bad_lat);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [63:0] d;
    logic [1:0]  resp;
    int lat, er;
    do_write(17'h10008, 64'hDEAD_BEEF_0123_4567, 0, resp, lat, er);
    model_mem[1] = 64'hDEAD_BEEF_0123_4567;
    n_total++;
    if (lat != WR_LAT) $display("FAIL wr_latency: got %0d expected %0d", lat, WR_LAT);
    else n_pass++;
    n_total++;
    if (resp !== 2'b00) $display("FAIL wr_resp: got %b expected 00", resp);
    else n_pass++;
    do_read(17'h10008, d, resp, lat);
    n_total++;
    if (lat != RD_LAT) $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT);
    else n_pass++;
    n_total++;
    if (d !== 64'hDEAD_BEEF_0123_4567 || resp !== 2'b00) $display("FAIL rd_after_wr: got %h/%b expected deadbeef01234567/00", d, resp);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    logic [1:0]  resp;
    int lat, er, bad;
    do_read(17'h10800, d, resp, lat);
    n_total++;
    if (d !== 64'h0 || resp !== 2'b10) $display("FAIL oor_read_above: got %h/%b expected 0/10", d, resp);
    else n_pass++;
    do_read(17'h10004, d, resp, lat);
    n_total++;
    if (d !== 64'h0 || resp !== 2'b10) $display("FAIL oor_read_misaligned: got %h/%b expected 0/10", d, resp);
    else n_pass++;
    do_write(17'h0FFF8, {$urandom, $urandom}, 0, resp, lat, er);
    n_total++;
    if (resp !== 2'b10 || lat != WR_LAT) $display("FAIL oor_write: got %b lat %0d expected 10 lat %0d", resp, lat, WR_LAT);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(17'(BASE_I + i * 8), d, resp, lat);
      if (d !== model_mem[i] || resp !== 2'b00) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL mem_sweep: got %0d wrong words expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [16:0] ra, wa;
    logic [63:0] wd, d;
    logic [1:0]  resp;
    int ir, iw, lat, er, bad;
    ir = int'($urandom_range(0, DEPTH - 1));
    iw = (ir + 1) % DEPTH;
    ra = 17'(BASE_I + ir * 8);
    wa = 17'(BASE_I + iw * 8);
    wd = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = ra;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = wa;
    @(negedge clk);
    n_total++;
    if ({bus.AR_READY, bus.AW_READY} !== 2'b10) $display("FAIL collide_ready: got %b expected 10", {bus.AR_READY, bus.AW_READY});
    else n_pass++;
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    bad = 0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.AW_READY) bad++;
      if (bus.R_VALID) begin lat = k; break; end
    end
    n_total++;
    if (bad != 0 || lat != RD_LAT) $display("FAIL collide_read_phase: got aw_ready %0d times lat %0d expected 0 and %0d", bad, lat, RD_LAT);
    else n_pass++;
    n_total++;
    if (bus.R_DATA !== model_mem[ir]) $display("FAIL collide_rdata: got %h expected %h", bus.R_DATA, model_mem[ir]);
    else n_pass++;
    bus.R_READY = 1'b1;
    @(posedge clk); #1;
    bus.R_READY = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.AW_READY !== 1'b1) $display("FAIL collide_aw_after: got %b expected 1", bus.AW_READY);
    else n_pass++;
    bus.AW_VALID = 1'b0;
    do_write(wa, wd, 0, resp, lat, er);
    model_mem[iw] = wd;
    do_read(wa, d, resp, lat);
    n_total++;
    if (d !== wd || resp !== 2'b00) $display("FAIL collide_write_data: got %h/%b expected %h/00", d, resp, wd);
    else n_pass++;
  endtask

  task automatic test_r_hold();
    logic [16:0] a1, a2;
    logic [63:0] d0, d;
    logic [1:0]  r0;
    int i1, i2, lat, bad;
    i1 = int'($urandom_range(0, DEPTH - 1));
    i2 = int'($urandom_range(0, DEPTH - 1));
    a1 = 17'(BASE_I + i1 * 8);
    a2 = 17'(BASE_I + i2 * 8);
    @(posedge clk); #1;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = a1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.R_VALID) begin lat = k; break; end
    end
    d0 = bus.R_DATA;
    r0 = bus.R_RESP;
    n_total++;
    if (lat != RD_LAT || d0 !== model_mem[i1] || r0 !== 2'b00) $display("FAIL hold_first: got lat %0d %h/%b expected lat %0d %h/00", lat, d0, r0, RD_LAT, model_mem[i1]);
    else n_pass++;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = a2;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus.AR_READY !== 1'b0) bad++;
      @(negedge clk);
      if (bus.R_VALID !== 1'b1 || bus.R_DATA !== d0 || bus.R_RESP !== r0 || bus.AR_READY !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL hold_stable: got %0d unstable samples expected 0", bad);
    else n_pass++;
    bus.R_READY = 1'b1;
    @(posedge clk); #1;
    bus.R_READY = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.R_VALID, bus.AR_READY} !== 2'b01) $display("FAIL hold_release: got %b expected 01", {bus.R_VALID, bus.AR_READY});
    else n_pass++;
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.R_VALID) begin lat = k; break; end
    end
    d = bus.R_DATA;
    n_total++;
    if (lat != RD_LAT || d !== model_mem[i2]) $display("FAIL hold_second: got lat %0d %h expected lat %0d %h", lat, d, RD_LAT, model_mem[i2]);
    else n_pass++;
    bus.R_READY = 1'b1;
    @(posedge clk); #1;
    bus.R_READY = 1'b0;
  endtask

  task automatic test_w_early();
    logic [16:0] a;
    logic [63:0] wd, d;
    logic [1:0]  resp;
    int i, lat, er;
    i  = int'($urandom_range(0, DEPTH - 1));
    a  = 17'(BASE_I + i * 8);
    wd = {$urandom, $urandom};
    do_write(a, wd, 3, resp, lat, er);
    model_mem[i] = wd;
    n_total++;
    if (er != 0) $display("FAIL w_early_ready: got %0d early W_READY samples expected 0", er);
    else n_pass++;
    n_total++;
    if (resp !== 2'b00 || lat != WR_LAT) $display("FAIL w_early_resp: got %b lat %0d expected 00 lat %0d", resp, lat, WR_LAT);
    else n_pass++;
    do_read(a, d, resp, lat);
    n_total++;
    if (d !== wd) $display("FAIL w_early_data: got %h expected %h", d, wd);
    else n_pass++;
  endtask

  task automatic test_ready_outside();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    bus.R_READY = 1'b1;
    bus.B_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.R_VALID !== 1'b0 || bus.B_VALID !== 1'b0 || bus.AR_READY !== 1'b1) bad++;
    end
    bus.R_READY = 1'b0;
    bus.B_READY = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL ready_outside: got %0d bad idle samples expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [16:0] a;
    logic [63:0] d, wd, exp_d;
    logic [1:0]  resp, exp_r;
    int lat, er;
    bit hit;
    for (int it = 0; it < 60; it++) begin
      a   = pick_addr();
      hit = m_hit(a);
      exp_r = hit ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        wd = {$urandom, $urandom};
        do_write(a, wd, int'($urandom_range(0, 2)), resp, lat, er);
        if (hit) model_mem[m_idx(a)] = wd;
        n_total++;
        if (resp !== exp_r || lat != WR_LAT) $display("FAIL rand_write it=%0d addr=%h: got %b lat %0d expected %b lat %0d", it, a, resp, lat, exp_r, WR_LAT);
        else n_pass++;
      end else begin
        exp_d = hit ? model_mem[m_idx(a)] : 64'h0;
        do_read(a, d, resp, lat);
        n_total++;
        if (d !== exp_d || resp !== exp_r || lat != RD_LAT) $display("FAIL rand_read it=%0d addr=%h: got %h/%b lat %0d expected %h/%b lat %0d", it, a, d, resp, lat, exp_d, exp_r, RD_LAT);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [16:0] a;
    logic [63:0] wd, d;
    logic [1:0]  resp;
    int i, lat, bad;
    i = int'($urandom_range(0, DEPTH - 1));
    a = 17'(BASE_I + i * 8);
    @(posedge clk); #1;
    bus.AR_VALID = 1'b1; bus.AR_ADDR = a;
    @(negedge clk);
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.R_VALID, bus.AR_READY} !== 2'b01) $display("FAIL rst_rd_wait: got %b expected 01", {bus.R_VALID, bus.AR_READY});
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.R_VALID) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rst_rd_no_resp: got %0d R_VALID samples expected 0", bad);
    else n_pass++;
    do_read(a, d, resp, lat);
    n_total++;
    if (d !== model_mem[i] || resp !== 2'b00) $display("FAIL rst_rd_mem: got %h/%b expected %h/00", d, resp, model_mem[i]);
    else n_pass++;

    i  = (i + 3) % DEPTH;
    a  = 17'(BASE_I + i * 8);
    wd = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.AW_VALID = 1'b1; bus.AW_ADDR = a;
    bus.W_VALID = 1'b1;  bus.W_DATA = wd;
    @(negedge clk);
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.W_VALID = 1'b0;
    model_mem[i] = wd;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.B_VALID || !bus.AW_READY) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rst_wr_no_resp: got %0d bad samples expected 0", bad);
    else n_pass++;
    do_read(a, d, resp, lat);
    n_total++;
    if (d !== wd) $display("FAIL rst_wr_committed: got %h expected %h", d, wd);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    test_reset();
    test_fill();
    test_write_read();
    test_out_of_range();
    test_collision();
    test_r_hold();
    test_w_early();
    test_ready_outside();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
